// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator.
// - alloc_state_e : allocator FSM encoding (IDLE=0, SCAN=1, COMMIT=2)
// - note_evt_t    : latched MIDI note event
// - zext7         : key/velocity zero-extension to the engine's 8-bit buses
package voice_allocator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } alloc_state_e;

  typedef struct packed {
    logic       on;
    logic [6:0] key;
    logic [6:0] vel;
  } note_evt_t;

  function automatic logic [7:0] zext7(input logic [6:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/voice_lru_rank.sv
// Least-recently-allocated ranking for the voice pool.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   alloc      : one-cycle strobe, voice `target` was just allocated
//   target     : allocated voice index
//   rank       : per-voice rank, 0 = newest, VOICES-1 = oldest
//   oldest     : lowest-index voice holding rank VOICES-1
module voice_lru_rank #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alloc,
  input  logic [V_WIDTH-1:0]                target,
  output logic [VOICES-1:0][V_WIDTH-1:0]    rank,
  output logic [V_WIDTH-1:0]                oldest
);

  logic [V_WIDTH-1:0] tgt_rank;
  assign tgt_rank = rank[target];

  // Target moves to the front; everything that was newer than it ages by one.
  // Voices older than the target keep their rank, so ranks stay a permutation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) rank[i] <= V_WIDTH'(i);
    end else if (alloc) begin
      for (int i = 0; i < VOICES; i++) begin
        if (V_WIDTH'(i) == target)   rank[i] <= '0;
        else if (rank[i] < tgt_rank) rank[i] <= rank[i] + 1'b1;
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int i = VOICES - 1; i >= 0; i--)
      if (rank[i] == V_WIDTH'(VOICES - 1)) oldest = V_WIDTH'(i);
  end

endmodule

// File: rtl/voice_allocator.sv
// Assigns MIDI note-on/off events to synth voices and drives synth_engine's
// note-event inputs. Each event takes VOICES+2 cycles: accept, one scan cycle
// per voice, commit.
// Ports:
//   OSC_CLK, reset_reg_N           : clock, async active-low reset
//   evt_valid/evt_ready            : event handshake (ready only in IDLE)
//   evt_on, evt_key, evt_vel       : note-on flag, key, velocity
//   sustain                        : sustain pedal level
//   voice_free                     : engine envelope-idle per voice
//   keys_on                        : per-voice gate (held | sustained)
//   note_on                        : one-cycle strobe per allocated note-on
//   cur_key_adr/val, cur_vel_on/off: last committed event towards the engine
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               OSC_CLK,
  input  logic               reset_reg_N,
  input  logic               evt_valid,
  output logic               evt_ready,
  input  logic               evt_on,
  input  logic [6:0]         evt_key,
  input  logic [6:0]         evt_vel,
  input  logic               sustain,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off
);

  alloc_state_e state, state_nx;
  note_evt_t    evt;

  logic [V_WIDTH-1:0]             idx;
  logic [VOICES-1:0][6:0]         key;
  logic [VOICES-1:0]              held, sus;
  logic                           sus_q;

  logic                           m_found, f_found, o_found;
  logic [V_WIDTH-1:0]             m_idx, f_idx, o_idx;

  logic [VOICES-1:0][V_WIDTH-1:0] rank;
  logic [V_WIDTH-1:0]             oldest;

  logic               accept, scan_last, do_on, do_off, sus_fall;
  logic [V_WIDTH-1:0] tgt, steal_idx;

  // Ready is gated by reset so it reads 0 while reset is held.
  assign evt_ready = (state == ST_IDLE) && reset_reg_N;
  assign keys_on   = held | sus;
  assign sus_fall  = sus_q && !sustain;

  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= ST_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    scan_last = 1'b0;
    case (state)
      ST_IDLE: if (evt_valid) begin
        accept   = 1'b1;
        state_nx = ST_SCAN;
      end
      ST_SCAN: if (idx == V_WIDTH'(VOICES - 1)) begin
        scan_last = 1'b1;
        state_nx  = ST_COMMIT;
      end
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Ranks do not move during a scan, so the scanned oldest always exists;
  // the rank block's own oldest is only a fallback.
  assign steal_idx = o_found ? o_idx : oldest;
  assign tgt       = m_found ? m_idx : (f_found ? f_idx : steal_idx);
  assign do_on     = (state == ST_COMMIT) && evt.on;
  assign do_off    = (state == ST_COMMIT) && !evt.on && m_found;

  voice_lru_rank #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_lru (
    .clk    (OSC_CLK),
    .rst_n  (reset_reg_N),
    .alloc  (do_on),
    .target (tgt),
    .rank   (rank),
    .oldest (oldest)
  );

  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      evt         <= '0;
      idx         <= '0;
      key         <= '0;
      held        <= '0;
      sus         <= '0;
      sus_q       <= 1'b0;
      m_found     <= 1'b0;
      f_found     <= 1'b0;
      o_found     <= 1'b0;
      m_idx       <= '0;
      f_idx       <= '0;
      o_idx       <= '0;
      note_on     <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
    end else begin
      sus_q   <= sustain;
      note_on <= 1'b0;

      if (accept) begin
        evt     <= '{on: evt_on, key: evt_key, vel: evt_vel};
        idx     <= '0;
        m_found <= 1'b0;
        f_found <= 1'b0;
        o_found <= 1'b0;
      end

      // First hit of each class wins; voice_free is only looked at here.
      if (state == ST_SCAN) begin
        if (!scan_last) idx <= idx + 1'b1;
        if (!m_found && key[idx] == evt.key && (held[idx] || sus[idx])) begin
          m_found <= 1'b1;
          m_idx   <= idx;
        end
        if (!f_found && voice_free[idx] && !held[idx]) begin
          f_found <= 1'b1;
          f_idx   <= idx;
        end
        if (!o_found && rank[idx] == V_WIDTH'(VOICES - 1)) begin
          o_found <= 1'b1;
          o_idx   <= idx;
        end
      end

      if (do_on) begin
        held[tgt]   <= 1'b1;
        sus[tgt]    <= 1'b0;
        key[tgt]    <= evt.key;
        note_on     <= 1'b1;
        cur_key_adr <= tgt;
        cur_key_val <= zext7(evt.key);
        cur_vel_on  <= zext7(evt.vel);
      end

      if (do_off) begin
        held[tgt]   <= 1'b0;
        sus[tgt]    <= sustain;
        cur_key_adr <= tgt;
        cur_vel_off <= zext7(evt.vel);
      end

      // Pedal release beats a same-cycle sustain write from COMMIT.
      if (sus_fall) sus <= '0;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
  localparam int VOICES  = 8;
  localparam int V_WIDTH = 3;

  logic               OSC_CLK = 1'b0;
  logic               reset_reg_N = 1'b0;
  logic               evt_valid = 1'b0;
  logic               evt_ready;
  logic               evt_on = 1'b0;
  logic [6:0]         evt_key = '0;
  logic [6:0]         evt_vel = '0;
  logic               sustain = 1'b0;
  logic [VOICES-1:0]  voice_free = '1;
  logic [VOICES-1:0]  keys_on;
  logic               note_on;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val, cur_vel_on, cur_vel_off;

  int n_pass  = 0;
  int n_total = 0;

  always #5 OSC_CLK = ~OSC_CLK;

  voice_allocator #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) dut (
    .OSC_CLK     (OSC_CLK),
    .reset_reg_N (reset_reg_N),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_on      (evt_on),
    .evt_key     (evt_key),
    .evt_vel     (evt_vel),
    .sustain     (sustain),
    .voice_free  (voice_free),
    .keys_on     (keys_on),
    .note_on     (note_on),
    .cur_key_adr (cur_key_adr),
    .cur_key_val (cur_key_val),
    .cur_vel_on  (cur_vel_on),
    .cur_vel_off (cur_vel_off)
  );

  // Sends one event and returns at the negedge after the commit edge.
  // pre = note_on one cycle before the commit outputs should appear.
  task automatic issue(input logic on, input logic [6:0] k, input logic [6:0] v, output logic pre);
    int w = 0;
    pre = 1'bx;
    while (!evt_ready && w < 20) begin @(negedge OSC_CLK); w++; end
    n_total++; if (evt_ready !== 1'b1) $display("FAIL issue_ready got %b want 1", evt_ready); else n_pass++;
    evt_valid = 1'b1; evt_on = on; evt_key = k; evt_vel = v;
    @(negedge OSC_CLK);
    evt_valid = 1'b0;
    for (int i = 1; i <= VOICES + 1; i++) begin
      @(negedge OSC_CLK);
      if (i == VOICES) pre = note_on;
    end
  endtask

  task automatic do_reset();
    @(negedge OSC_CLK);
    reset_reg_N = 1'b0; evt_valid = 1'b0; sustain = 1'b0;
    repeat (2) @(negedge OSC_CLK);
    reset_reg_N = 1'b1;
    @(negedge OSC_CLK);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge OSC_CLK);
    n_total++; if (evt_ready !== 1'b0) $display("FAIL rst_ready_in_reset got %b want 0", evt_ready); else n_pass++;
    n_total++; if (keys_on !== 8'h00) $display("FAIL rst_keys got %h want 00", keys_on); else n_pass++;
    n_total++; if (note_on !== 1'b0) $display("FAIL rst_note_on got %b want 0", note_on); else n_pass++;
    reset_reg_N = 1'b1;
    #1;
    n_total++; if (evt_ready !== 1'b1) $display("FAIL rst_ready_after got %b want 1", evt_ready); else n_pass++;
    n_total++; if (cur_key_adr !== 3'd0) $display("FAIL rst_adr got %0d want 0", cur_key_adr); else n_pass++;
    n_total++; if (cur_key_val !== 8'd0) $display("FAIL rst_key_val got %0d want 0", cur_key_val); else n_pass++;
    n_total++; if (cur_vel_on !== 8'd0) $display("FAIL rst_vel_on got %0d want 0", cur_vel_on); else n_pass++;
    n_total++; if (cur_vel_off !== 8'd0) $display("FAIL rst_vel_off got %0d want 0", cur_vel_off); else n_pass++;
    @(negedge OSC_CLK);
  endtask

  task automatic test_basic();
    logic pre;
    voice_free = 8'hFF;
    issue(1'b1, 7'd60, 7'd100, pre);
    n_total++; if (pre !== 1'b0) $display("FAIL basic_early_strobe got %b want 0", pre); else n_pass++;
    n_total++; if (note_on !== 1'b1) $display("FAIL basic_note_on got %b want 1", note_on); else n_pass++;
    n_total++; if (cur_key_adr !== 3'd0) $display("FAIL basic_adr got %0d want 0", cur_key_adr); else n_pass++;
    n_total++; if (cur_key_val !== 8'd60) $display("FAIL basic_key_val got %0d want 60", cur_key_val); else n_pass++;
    n_total++; if (cur_vel_on !== 8'd100) $display("FAIL basic_vel_on got %0d want 100", cur_vel_on); else n_pass++;
    n_total++; if (keys_on !== 8'h01) $display("FAIL basic_keys got %h want 01", keys_on); else n_pass++;
    @(negedge OSC_CLK);
    n_total++; if (note_on !== 1'b0) $display("FAIL basic_strobe_end got %b want 0", note_on); else n_pass++;
  endtask

  task automatic test_retrigger();
    logic pre;
    issue(1'b1, 7'd64, 7'd80, pre);
    n_total++; if (cur_key_adr !== 3'd1) $display("FAIL retrig_second_adr got %0d want 1", cur_key_adr); else n_pass++;
    n_total++; if (keys_on !== 8'h03) $display("FAIL retrig_second_keys got %h want 03", keys_on); else n_pass++;
    issue(1'b1, 7'd64, 7'd50, pre);
    n_total++; if (note_on !== 1'b1) $display("FAIL retrig_note_on got %b want 1", note_on); else n_pass++;
    n_total++; if (cur_key_adr !== 3'd1) $display("FAIL retrig_adr got %0d want 1", cur_key_adr); else n_pass++;
    n_total++; if (cur_vel_on !== 8'd50) $display("FAIL retrig_vel_on got %0d want 50", cur_vel_on); else n_pass++;
    n_total++; if (keys_on !== 8'h03) $display("FAIL retrig_keys got %h want 03", keys_on); else n_pass++;
  endtask

  task automatic test_note_off();
    logic pre;
    issue(1'b0, 7'd60, 7'd40, pre);
    n_total++; if (keys_on !== 8'h02) $display("FAIL off_keys got %h want 02", keys_on); else n_pass++;
    n_total++; if (cur_vel_off !== 8'd40) $display("FAIL off_vel_off got %0d want 40", cur_vel_off); else n_pass++;
    n_total++; if (cur_key_adr !== 3'd0) $display("FAIL off_adr got %0d want 0", cur_key_adr); else n_pass++;
    n_total++; if (note_on !== 1'b0) $display("FAIL off_note_on got %b want 0", note_on); else n_pass++;
  endtask

  task automatic test_unmatched_off();
    logic pre;
    issue(1'b0, 7'd99, 7'd10, pre);
    n_total++; if (keys_on !== 8'h02) $display("FAIL unm_keys got %h want 02", keys_on); else n_pass++;
    n_total++; if (cur_key_adr !== 3'd0) $display("FAIL unm_adr got %0d want 0", cur_key_adr); else n_pass++;
    n_total++; if (cur_vel_off !== 8'd40) $display("FAIL unm_vel_off got %0d want 40", cur_vel_off); else n_pass++;
    n_total++; if (cur_vel_on !== 8'd50) $display("FAIL unm_vel_on got %0d want 50", cur_vel_on); else n_pass++;
    n_total++; if (note_on !== 1'b0) $display("FAIL unm_note_on got %b want 0", note_on); else n_pass++;
  endtask

  task automatic test_steal();
    logic pre;
    do_reset();
    voice_free = 8'hFF;
    for (int k = 0; k < VOICES; k++) issue(1'b1, 7'(60 + k), 7'd64, pre);
    n_total++; if (keys_on !== 8'hFF) $display("FAIL steal_fill_keys got %h want ff", keys_on); else n_pass++;
    n_total++; if (cur_key_adr !== 3'd7) $display("FAIL steal_fill_adr got %0d want 7", cur_key_adr); else n_pass++;
    voice_free = 8'h00;
    issue(1'b1, 7'd70, 7'd90, pre);
    n_total++; if (cur_key_adr !== 3'd0) $display("FAIL steal_9th_adr got %0d want 0", cur_key_adr); else n_pass++;
    n_total++; if (cur_key_val !== 8'd70) $display("FAIL steal_9th_key got %0d want 70", cur_key_val); else n_pass++;
    n_total++; if (note_on !== 1'b1) $display("FAIL steal_9th_note_on got %b want 1", note_on); else n_pass++;
    issue(1'b1, 7'd71, 7'd90, pre);
    n_total++; if (cur_key_adr !== 3'd1) $display("FAIL steal_10th_adr got %0d want 1", cur_key_adr); else n_pass++;
    n_total++; if (keys_on !== 8'hFF) $display("FAIL steal_10th_keys got %h want ff", keys_on); else n_pass++;
  endtask

  task automatic test_sustain();
    logic pre;
    do_reset();
    voice_free = 8'hFF;
    issue(1'b1, 7'd60, 7'd90, pre);
    sustain = 1'b1;
    issue(1'b0, 7'd60, 7'd33, pre);
    n_total++; if (keys_on !== 8'h01) $display("FAIL sus_hold_keys got %h want 01", keys_on); else n_pass++;
    n_total++; if (cur_vel_off !== 8'd33) $display("FAIL sus_vel_off got %0d want 33", cur_vel_off); else n_pass++;
    sustain = 1'b0;
    @(negedge OSC_CLK);
    n_total++; if (keys_on !== 8'h00) $display("FAIL sus_release_keys got %h want 00", keys_on); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    logic pre;
    issue(1'b1, 7'd61, 7'd70, pre);
    n_total++; if (keys_on !== 8'h01) $display("FAIL mid_pre_keys got %h want 01", keys_on); else n_pass++;
    evt_valid = 1'b1; evt_on = 1'b1; evt_key = 7'd62; evt_vel = 7'd70;
    @(negedge OSC_CLK);
    evt_valid = 1'b0;
    repeat (3) @(negedge OSC_CLK);
    reset_reg_N = 1'b0;
    #1;
    n_total++; if (keys_on !== 8'h00) $display("FAIL mid_keys got %h want 00", keys_on); else n_pass++;
    n_total++; if (cur_key_val !== 8'd0) $display("FAIL mid_key_val got %0d want 0", cur_key_val); else n_pass++;
    n_total++; if (evt_ready !== 1'b0) $display("FAIL mid_ready_in_reset got %b want 0", evt_ready); else n_pass++;
    @(negedge OSC_CLK);
    reset_reg_N = 1'b1;
    #1;
    n_total++; if (evt_ready !== 1'b1) $display("FAIL mid_ready_after got %b want 1", evt_ready); else n_pass++;
    issue(1'b1, 7'd65, 7'd20, pre);
    n_total++; if (cur_key_adr !== 3'd0) $display("FAIL mid_recover_adr got %0d want 0", cur_key_adr); else n_pass++;
    n_total++; if (keys_on !== 8'h01) $display("FAIL mid_recover_keys got %h want 01", keys_on); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retrigger();
    test_note_off();
    test_unmatched_off();
    test_steal();
    test_sustain();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Assigns incoming MIDI note-on/note-off events to synthesizer voices and drives the note-event inputs of `synth_engine` (`keys_on`, `note_on`, `cur_key_adr`, `cur_key_val`, `cur_vel_on`, `cur_vel_off`). It sits between the MIDI decoder and `synth_engine`. A sequential scan over all voices picks the target voice: same-key retrigger first, then a free voice, then steals the least-recently-allocated voice. The engine's `voice_free` vector is the free/idle indication.

## Interface
- `VOICES`, 8, number of voices
- `V_WIDTH`, 3, log2(VOICES)
- `OSC_CLK` in 1: sole clock, all logic on rising edge
- `reset_reg_N` in 1: asynchronous, active-low reset
- `evt_valid` in 1: event present
- `evt_ready` out 1: block can accept; high only in IDLE
- `evt_on` in 1: 1 = note-on, 0 = note-off
- `evt_key` in 7: MIDI key number
- `evt_vel` in 7: MIDI velocity
- `sustain` in 1: sustain pedal level
- `voice_free` in VOICES: from engine; bit set = envelope idle
- `keys_on` out VOICES: gate per voice
- `note_on` out 1: one-cycle strobe for an allocated note-on
- `cur_key_adr` out V_WIDTH: voice touched by the last event
- `cur_key_val` out 8: {1'b0, key}
- `cur_vel_on` out 8: {1'b0, note-on velocity}
- `cur_vel_off` out 8: {1'b0, note-off velocity}

## Operation
- **Per-voice state:** `key[6:0]`, `held` (= `keys_on` bit), `sus` (released while pedal down), `rank[V_WIDTH-1:0]` (0 = newest, VOICES-1 = oldest).
- **FSM states:** IDLE → SCAN → COMMIT → IDLE.
- **IDLE:** `evt_ready`=1. When `evt_valid`=1, latch `evt_on`, `evt_key` and `evt_vel`, clear the scan index, and go to SCAN.
- **SCAN:** examines voice `idx` each cycle, for `idx` = 0..VOICES-1, then goes to COMMIT. It records the first match of each class:
  - `match`: `key`==evt_key and (`held` or `sus`)
  - `free`: `voice_free`=1 and `held`=0
  - `oldest`: `rank`==VOICES-1
- **COMMIT, note-on:** the target is `match` if found, else `free`, else `oldest`.
  - `held`=1, `sus`=0, `key`=evt_key.
  - Drive `cur_key_adr`=target, `cur_key_val`, `cur_vel_on`, and `note_on`=1.
  - LRU update: the target's rank becomes 0. Every voice whose rank is below the target's old rank increments by 1.
- **COMMIT, note-off with `match`:**
  - If `sustain`=1: `held`=0, `sus`=1, and `keys_on` stays 1.
  - Otherwise: `held`=0, `sus`=0, and the `keys_on` bit clears.
  - Drive `cur_key_adr`=target and `cur_vel_off`. `note_on` stays 0.
- **COMMIT, note-off without `match`:** no state or output change.
- **`keys_on[i]`** = `held[i]` | `sus[i]`.
- **Sustain release:** a falling edge of `sustain`, detected by a registered copy, clears every `sus` bit in the same cycle in any state. If COMMIT is in that same cycle and sets `sus`, that write loses: the voice is released.

## Timing
- **Reset values:** `evt_ready`=0 during reset and 1 in the first cycle after release. `keys_on`=0, `note_on`=0, `cur_*`=0, `held`=`sus`=0, `key`=0, and `rank[i]`=i.
- **Event timeline:** an event is accepted at edge t. SCAN covers edges t+1..t+VOICES. COMMIT outputs become visible after edge t+VOICES+1.
- **`note_on` strobe:** high for exactly one cycle. `cur_*` and `keys_on` update in the same cycle and hold until the next commit.
- **Throughput:** one event per VOICES+2 cycles. `evt_valid` must be held until `evt_ready`. Events are never dropped or reordered.
- **`voice_free` sampling:** each bit is sampled live during its voice's SCAN cycle. No stability is required beyond that cycle.
- **Reset mid-scan:** the event is abandoned and all state returns to reset values.

## Structure
- Shared synth package/header holds the FSM state encoding (IDLE=0, SCAN=1, COMMIT=2) and the output zero-extension convention for key/velocity.
- Sub-module `voice_lru_rank`: VOICES rank registers and the update-on-allocate logic. It outputs `oldest` index and the per-voice rank.

## Test plan
- **Basic allocation:** reset, all `voice_free`=1; note-on key 60 vel 100 → `note_on` pulse at VOICES+2 cycles, `cur_key_adr`=0, `cur_key_val`=60, `cur_vel_on`=100, `keys_on`=8'h01.
- **Retrigger:** voices 0 and 1 hold keys 60 and 64; note-on key 64 vel 50 → reused voice 1, `keys_on` unchanged, `cur_vel_on`=50.
- **Note-off:** note-off key 60 vel 40 → `keys_on` bit 0 clears, `cur_vel_off`=40, no `note_on`.
- **Unmatched note-off:** note-off for key 99 → no output change.
- **Voice stealing:** fill all 8 voices with keys 60..67, `voice_free`=0 → a 9th note-on (key 70) steals voice 0. A 10th steals voice 1.
- **Sustain:** `sustain`=1, note-off key 60 → `keys_on` bit 0 stays 1. Drop `sustain` → bit 0 clears the next cycle. Assert reset during SCAN → all outputs 0, `evt_ready`=1 after release.
